// File: rtl/cv32e40p_obi_pkg.sv
// rtl/cv32e40p_obi_pkg.sv - shared types and byte-lane merge for the OBI data responder
package cv32e40p_obi_pkg;

    localparam int OBI_DATA_W = 32;
    localparam int OBI_BE_W   = 4;

    typedef struct packed {
        logic                  valid;
        logic [OBI_DATA_W-1:0] rdata;
    } obi_resp_t;

    function automatic logic [OBI_DATA_W-1:0] be_merge(
        input logic [OBI_DATA_W-1:0] old_word,
        input logic [OBI_DATA_W-1:0] new_word,
        input logic [OBI_BE_W-1:0]   be
    );
        logic [OBI_DATA_W-1:0] res;
        res = old_word;
        for (int k = 0; k < OBI_BE_W; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cv32e40p_obi_data_responder_if.sv
// rtl/cv32e40p_obi_data_responder_if.sv - OBI data request/response bus between core and memory
interface cv32e40p_obi_data_responder_if;
    import cv32e40p_obi_pkg::*;

    logic                  data_req;
    logic                  data_gnt;
    logic                  data_rvalid;
    logic                  data_we;
    logic [OBI_BE_W-1:0]   data_be;
    logic [31:0]           data_addr;
    logic [OBI_DATA_W-1:0] data_wdata;
    logic [OBI_DATA_W-1:0] data_rdata;

    modport master (
        output data_req, data_we, data_be, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata
    );

    modport slave (
        input  data_req, data_we, data_be, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata
    );

endinterface

// File: rtl/cv32e40p_obi_resp_pipe.sv
// rtl/cv32e40p_obi_resp_pipe.sv - fixed-latency shift register carrying responses in grant order
module cv32e40p_obi_resp_pipe
    import cv32e40p_obi_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  obi_resp_t in_resp,
    output obi_resp_t out_resp
);

    obi_resp_t stage_q [LATENCY];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= in_resp;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_resp = stage_q[LATENCY-1];

endmodule

// File: rtl/cv32e40p_obi_data_responder.sv
// rtl/cv32e40p_obi_data_responder.sv - OBI data memory: grant with slot limit, word memory, in-order responses
module cv32e40p_obi_data_responder
    import cv32e40p_obi_pkg::*;
#(
    parameter int ADDR_WIDTH      = 10,
    parameter int RESP_LATENCY    = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            stall_i,
    cv32e40p_obi_data_responder_if.slave    bus,
    output logic [2:0]                      outstanding_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [OBI_DATA_W-1:0] mem [DEPTH];
    logic [2:0]            outstanding_q;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  gnt;
    obi_resp_t             grant_resp;
    obi_resp_t             pipe_out;
    logic                  unused_addr_bits;

    // Upper address bits alias onto the same word; byte offset is meaningless for word access.
    assign idx              = bus.data_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{bus.data_addr[31:ADDR_WIDTH+2], bus.data_addr[1:0]};

    // Registered count only: a response leaving this cycle frees its slot next cycle.
    assign gnt = bus.data_req & ~stall_i & ~rst_i
               & (outstanding_q < 3'(MAX_OUTSTANDING));

    always_comb begin
        grant_resp.valid = gnt;
        grant_resp.rdata = '0;
        if (gnt && !bus.data_we) begin
            grant_resp.rdata = mem[idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt && bus.data_we) begin
            mem[idx] <= be_merge(mem[idx], bus.data_wdata, bus.data_be);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_q <= 3'd0;
        end else begin
            case ({gnt, pipe_out.valid})
                2'b10:   outstanding_q <= outstanding_q + 3'd1;
                2'b01:   outstanding_q <= outstanding_q - 3'd1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    cv32e40p_obi_resp_pipe #(
        .LATENCY (RESP_LATENCY)
    ) u_resp_pipe (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .in_resp  (grant_resp),
        .out_resp (pipe_out)
    );

    assign bus.data_gnt    = gnt;
    assign bus.data_rvalid = pipe_out.valid;
    assign bus.data_rdata  = pipe_out.rdata;
    assign outstanding_o   = outstanding_q;

    a_param_range: assert property (@(posedge clk_i)
        (RESP_LATENCY >= 1) && (RESP_LATENCY <= 4) &&
        (MAX_OUTSTANDING >= 1) && (MAX_OUTSTANDING <= 4));

    a_outstanding_max: assert property (@(posedge clk_i) disable iff (rst_i)
        outstanding_q <= 3'(MAX_OUTSTANDING));

    a_rvalid_needs_count: assert property (@(posedge clk_i) disable iff (rst_i)
        pipe_out.valid |-> (outstanding_q != 3'd0));

endmodule

// File: tb/tb_cv32e40p_obi_data_responder.sv
// tb/tb_cv32e40p_obi_data_responder.sv - self-checking bench: LAT=1 and LAT=3 responders against a queue model
module tb_cv32e40p_obi_data_responder;

    localparam int MAX_OUT = 2;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s   [2];
    logic        stall_s [2];
    logic        req_s   [2];
    logic        we_s    [2];
    logic [3:0]  be_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_s [2];
    logic        gnt_s   [2];
    logic        rv_s    [2];
    logic [2:0]  out_s   [2];

    cv32e40p_obi_data_responder_if bus0();
    cv32e40p_obi_data_responder_if bus1();

    assign bus0.data_req   = req_s[0];
    assign bus0.data_we    = we_s[0];
    assign bus0.data_be    = be_s[0];
    assign bus0.data_addr  = addr_s[0];
    assign bus0.data_wdata = wdata_s[0];
    assign gnt_s[0]        = bus0.data_gnt;
    assign rv_s[0]         = bus0.data_rvalid;
    assign rdata_s[0]      = bus0.data_rdata;

    assign bus1.data_req   = req_s[1];
    assign bus1.data_we    = we_s[1];
    assign bus1.data_be    = be_s[1];
    assign bus1.data_addr  = addr_s[1];
    assign bus1.data_wdata = wdata_s[1];
    assign gnt_s[1]        = bus1.data_gnt;
    assign rv_s[1]         = bus1.data_rvalid;
    assign rdata_s[1]      = bus1.data_rdata;

    cv32e40p_obi_data_responder #(
        .ADDR_WIDTH (10), .RESP_LATENCY (1), .MAX_OUTSTANDING (MAX_OUT)
    ) dut0 (
        .clk_i (clk), .rst_i (rst_s[0]), .stall_i (stall_s[0]),
        .bus (bus0), .outstanding_o (out_s[0])
    );

    cv32e40p_obi_data_responder #(
        .ADDR_WIDTH (10), .RESP_LATENCY (3), .MAX_OUTSTANDING (MAX_OUT)
    ) dut1 (
        .clk_i (clk), .rst_i (rst_s[1]), .stall_i (stall_s[1]),
        .bus (bus1), .outstanding_o (out_s[1])
    );

    int ncmp = 0;
    int nerr = 0;
    int unsigned cyc = 0;

    // Model: pending responses per DUT as (cycle due, data), memory as plain arrays.
    resp_t       q0[$];
    resp_t       q1[$];
    logic [31:0] mem_m [2][1024];

    logic        obs_gnt, obs_rv, exp_gnt, exp_rv;
    logic [31:0] obs_rd, exp_rd;
    logic [2:0]  obs_out, exp_out;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic drive(input int d, input logic r, input logic w,
                         input logic [31:0] a, input logic [3:0] b, input logic [31:0] wd);
        req_s[d] = r; we_s[d] = w; addr_s[d] = a; be_s[d] = b; wdata_s[d] = wd;
    endtask

    task automatic idle(input int d);
        drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // One clock for DUT d: sample just after negedge, update model at posedge, return at next negedge.
    task automatic tick(input int d);
        resp_t q[$];
        int unsigned idx;
        if (d == 0) q = q0; else q = q1;
        #1;
        obs_gnt = gnt_s[d]; obs_rv = rv_s[d]; obs_rd = rdata_s[d]; obs_out = out_s[d];
        exp_out = 3'(q.size());
        exp_rv  = (q.size() > 0) && (q[0].due == cyc);
        exp_rd  = exp_rv ? q[0].data : 32'h0;
        exp_gnt = req_s[d] && !stall_s[d] && !rst_s[d] && (q.size() < MAX_OUT);
        @(posedge clk);
        if (rst_s[d]) begin
            q.delete();
        end else begin
            if (exp_rv) void'(q.pop_front());
            if (exp_gnt) begin
                idx = 32'(addr_s[d][11:2]);
                if (we_s[d]) begin
                    for (int k = 0; k < 4; k++)
                        if (be_s[d][k]) mem_m[d][idx][8*k +: 8] = wdata_s[d][8*k +: 8];
                    q.push_back('{cyc + lat_of(d), 32'h0});
                end else begin
                    q.push_back('{cyc + lat_of(d), mem_m[d][idx]});
                end
            end
        end
        cyc++;
        if (d == 0) q0 = q; else q1 = q;
        @(negedge clk);
    endtask

    task automatic drain(input int d);
        int n = 0;
        idle(d);
        stall_s[d] = 1'b0;
        while (qsize(d) != 0 && n < 20) begin tick(d); n++; end
        tick(d);
        if (n >= 20) begin
            ncmp++; nerr++;
            $display("FAIL drain_timeout dut%0d: pending=%0d want 0", d, qsize(d));
        end
    endtask

    task automatic wait_grant(input int d);
        int n = 0;
        do begin tick(d); n++; end while (!obs_gnt && n < 40);
        if (!obs_gnt) begin
            ncmp++; nerr++;
            $display("FAIL grant_timeout dut%0d: gnt=%b want 1", d, obs_gnt);
        end
    endtask

    task automatic do_write(input int d, input logic [31:0] a, input logic [3:0] b, input logic [31:0] wd);
        drive(d, 1'b1, 1'b1, a, b, wd);
        wait_grant(d);
        drain(d);
    endtask

    task automatic do_read(input int d, input logic [31:0] a, output logic [31:0] rd);
        bit got = 1'b0;
        rd = 32'hx;
        drive(d, 1'b1, 1'b0, a, 4'h0, 32'h0);
        wait_grant(d);
        idle(d);
        for (int n = 0; n < 10 && !got; n++) begin
            tick(d);
            if (obs_rv) begin rd = obs_rd; got = 1'b1; end
        end
        if (!got) begin
            ncmp++; nerr++;
            $display("FAIL rvalid_timeout dut%0d: rvalid=%b want 1", d, obs_rv);
        end
        drain(d);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin rst_s[d] = 1'b1; stall_s[d] = 1'b0; end
        drive(0, 1'b1, 1'b1, 32'h0, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b1, 32'h0, 4'hF, 32'h0);
        tick(0);
        tick(0);
        for (int d = 0; d < 2; d++) begin
            tick(d);
            ncmp++; if (obs_gnt !== 1'b0) begin nerr++; $display("FAIL reset_gnt dut%0d: got %b want 0", d, obs_gnt); end
            ncmp++; if (obs_rv !== 1'b0) begin nerr++; $display("FAIL reset_rvalid dut%0d: got %b want 0", d, obs_rv); end
            ncmp++; if (obs_rd !== 32'h0) begin nerr++; $display("FAIL reset_rdata dut%0d: got %h want 0", d, obs_rd); end
            ncmp++; if (obs_out !== 3'd0) begin nerr++; $display("FAIL reset_outstanding dut%0d: got %0d want 0", d, obs_out); end
        end
        idle(0); idle(1);
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;
        tick(0);
    endtask

    task automatic test_write_read();
        drive(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        tick(0);
        ncmp++; if (obs_gnt !== 1'b1) begin nerr++; $display("FAIL wr_gnt: got %b want 1", obs_gnt); end
        drive(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        tick(0);
        ncmp++; if (obs_gnt !== 1'b1) begin nerr++; $display("FAIL rd_gnt: got %b want 1", obs_gnt); end
        ncmp++; if (obs_rv !== 1'b1) begin nerr++; $display("FAIL wr_rvalid_lat1: got %b want 1", obs_rv); end
        ncmp++; if (obs_rd !== 32'h0) begin nerr++; $display("FAIL wr_resp_rdata: got %h want 0", obs_rd); end
        idle(0);
        tick(0);
        ncmp++; if (obs_rv !== 1'b1) begin nerr++; $display("FAIL rd_rvalid_lat1: got %b want 1", obs_rv); end
        ncmp++; if (obs_rd !== 32'hDEADBEEF) begin nerr++; $display("FAIL rd_rdata: got %h want deadbeef", obs_rd); end
        ncmp++; if (obs_out !== 3'd1) begin nerr++; $display("FAIL wr_rd_outstanding: got %0d want 1", obs_out); end
        tick(0);
        ncmp++; if (obs_rv !== 1'b0) begin nerr++; $display("FAIL rd_rvalid_single: got %b want 0", obs_rv); end
        ncmp++; if (obs_out !== 3'd0) begin nerr++; $display("FAIL rd_outstanding_idle: got %0d want 0", obs_out); end
        drain(0);
    endtask

    task automatic test_byte_enables();
        drive(0, 1'b1, 1'b1, 32'h20, 4'hF, 32'hFFFFFFFF);
        tick(0);
        ncmp++; if (obs_gnt !== 1'b1) begin nerr++; $display("FAIL be_gnt0: got %b want 1", obs_gnt); end
        drive(0, 1'b1, 1'b1, 32'h20, 4'b0101, 32'h00000000);
        tick(0);
        ncmp++; if (obs_gnt !== 1'b1) begin nerr++; $display("FAIL be_gnt1: got %b want 1", obs_gnt); end
        drive(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        tick(0);
        ncmp++; if (obs_gnt !== 1'b1) begin nerr++; $display("FAIL be_gnt2: got %b want 1", obs_gnt); end
        idle(0);
        tick(0);
        ncmp++; if (obs_rv !== 1'b1) begin nerr++; $display("FAIL be_rvalid: got %b want 1", obs_rv); end
        ncmp++; if (obs_rd !== 32'hFF00FF00) begin nerr++; $display("FAIL be_rdata: got %h want ff00ff00", obs_rd); end
        drain(0);
    endtask

    task automatic test_stall();
        stall_s[0] = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick(0);
            ncmp++; if (obs_gnt !== 1'b0) begin nerr++; $display("FAIL stall_gnt cycle %0d: got %b want 0", i, obs_gnt); end
        end
        stall_s[0] = 1'b0;
        tick(0);
        ncmp++; if (obs_gnt !== 1'b1) begin nerr++; $display("FAIL stall_release_gnt: got %b want 1", obs_gnt); end
        idle(0);
        tick(0);
        ncmp++; if (obs_rv !== 1'b1 || obs_rd !== 32'hDEADBEEF) begin
            nerr++; $display("FAIL stall_resp: rvalid=%b rdata=%h want 1/deadbeef", obs_rv, obs_rd);
        end
        drain(0);
    endtask

    task automatic test_aliasing();
        logic [31:0] rd;
        do_write(0, 32'h0000_0004, 4'hF, 32'h12345678);
        do_read(0, 32'h0000_1004, rd);
        ncmp++; if (rd !== 32'h12345678) begin nerr++; $display("FAIL alias_rdata: got %h want 12345678", rd); end
    endtask

    task automatic test_outstanding_limit();
        logic [31:0] vals [4];
        logic [9:0]  g_exp;
        logic [9:0]  v_exp;
        int k = 0;
        int r = 0;
        for (int i = 0; i < 4; i++) begin
            vals[i] = $urandom();
            do_write(1, 32'h40 + 32'(4 * i), 4'hF, vals[i]);
        end
        g_exp = 10'h033;
        v_exp = 10'h198;
        for (int i = 0; i < 10; i++) begin
            drive(1, k < 4, 1'b0, 32'h40 + 32'(4 * k), 4'h0, 32'h0);
            tick(1);
            ncmp++; if (obs_gnt !== g_exp[i]) begin nerr++; $display("FAIL lim_gnt cycle %0d: got %b want %b", i, obs_gnt, g_exp[i]); end
            ncmp++; if (obs_rv !== v_exp[i]) begin nerr++; $display("FAIL lim_rvalid cycle %0d: got %b want %b", i, obs_rv, v_exp[i]); end
            ncmp++; if (!(obs_out inside {3'd0, 3'd1, 3'd2})) begin nerr++; $display("FAIL lim_outstanding cycle %0d: got %0d want <=2", i, obs_out); end
            if (obs_rv === 1'b1 && r < 4) begin
                ncmp++; if (obs_rd !== vals[r]) begin nerr++; $display("FAIL lim_order resp %0d: got %h want %h", r, obs_rd, vals[r]); end
                r++;
            end
            if (obs_gnt === 1'b1) k++;
        end
        ncmp++; if (r != 4) begin nerr++; $display("FAIL lim_resp_count: got %0d want 4", r); end
        drain(1);
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd;
        drive(1, 1'b1, 1'b1, 32'h84, 4'hF, 32'hCAFEF00D);
        tick(1);
        ncmp++; if (obs_gnt !== 1'b1) begin nerr++; $display("FAIL mid_gnt0: got %b want 1", obs_gnt); end
        drive(1, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        tick(1);
        ncmp++; if (obs_gnt !== 1'b1) begin nerr++; $display("FAIL mid_gnt1: got %b want 1", obs_gnt); end
        idle(1);
        rst_s[1] = 1'b1;
        tick(1);
        ncmp++; if (obs_rv !== 1'b0) begin nerr++; $display("FAIL mid_rvalid_rst: got %b want 0", obs_rv); end
        rst_s[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            ncmp++; if (obs_rv !== 1'b0) begin nerr++; $display("FAIL mid_rvalid_after cycle %0d: got %b want 0", i, obs_rv); end
            ncmp++; if (obs_out !== 3'd0) begin nerr++; $display("FAIL mid_outstanding cycle %0d: got %0d want 0", i, obs_out); end
        end
        do_read(1, 32'h84, rd);
        ncmp++; if (rd !== 32'hCAFEF00D) begin nerr++; $display("FAIL mid_write_kept: got %h want cafef00d", rd); end
    endtask

    task automatic test_random(input int d);
        logic [31:0] rnd;
        logic [3:0]  widx;
        int n;
        for (int i = 0; i < 16; i++) do_write(d, 32'(4 * i), 4'hF, $urandom());
        for (int t = 0; t < 150; t++) begin
            rnd  = $urandom();
            widx = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) idle(d);
            else drive(d, 1'b1, 1'($urandom_range(0, 1)), {rnd[31:12], 6'b0, widx, rnd[1:0]},
                       4'($urandom_range(0, 15)), $urandom());
            n = 0;
            do begin
                stall_s[d] = ($urandom_range(0, 3) == 0);
                tick(d);
                n++;
                ncmp++; if (obs_gnt !== exp_gnt) begin nerr++; $display("FAIL rnd%0d_gnt t=%0d: got %b want %b", d, t, obs_gnt, exp_gnt); end
                ncmp++; if (obs_rv !== exp_rv) begin nerr++; $display("FAIL rnd%0d_rvalid t=%0d: got %b want %b", d, t, obs_rv, exp_rv); end
                ncmp++; if (obs_rd !== exp_rd) begin nerr++; $display("FAIL rnd%0d_rdata t=%0d: got %h want %h", d, t, obs_rd, exp_rd); end
                ncmp++; if (obs_out !== exp_out) begin nerr++; $display("FAIL rnd%0d_outstanding t=%0d: got %0d want %0d", d, t, obs_out, exp_out); end
            end while (req_s[d] && !obs_gnt && n < 40);
            if (req_s[d] && !obs_gnt) begin
                ncmp++; nerr++;
                $display("FAIL rnd%0d_grant_timeout t=%0d: gnt=%b want 1", d, t, obs_gnt);
            end
        end
        drain(d);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b1; stall_s[d] = 1'b0;
            idle(d);
        end
        @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_enables();
        test_stall();
        test_aliasing();
        test_outstanding_limit();
        test_reset_midflight();
        test_random(0);
        test_random(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", ncmp, nerr);
        $fatal(1);
    end

endmodule
